// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment display path.
// The digit index type is also what the downstream digit multiplexer's CONTROL input uses.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } phase_e;

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot prescaler: counts 0..CLK_DIV-1 and flags the last cycle of each slot.
// A synchronous clear holds the count at zero so a restarted scan always begins a fresh slot.
module slot_timer #(
    parameter int CLK_DIV = 100000,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] slot_cnt_o,
    output logic             slot_wrap_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_cnt_o  = cnt_q;
    assign slot_wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexes four seven-segment digits: each slot opens with a dark blanking
// interval so the digit mux and decoder settle before the selected anode is driven low.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [3:0] DIGIT_MASK,
    output logic [1:0] SEG_SELECT,
    output logic [3:0] DIGIT_ANODE,
    output logic       SCAN_TICK
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam phase_e SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    phase_e                  state_q;
    phase_e                  state_d;
    digit_idx_t              seg_q;
    digit_idx_t              seg_d;
    logic [NUM_DIGITS-1:0]   anode_q;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic                    tick_q;
    logic                    tick_d;
    logic [CNT_W-1:0]        slot_cnt;
    logic                    slot_wrap;
    logic                    timer_clear;

    assign timer_clear = !ENABLE || (state_q == IDLE);

    slot_timer #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_slot_timer (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .clear_i     (timer_clear),
        .slot_cnt_o  (slot_cnt),
        .slot_wrap_o (slot_wrap)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions are taken on the edge where the count enters the new phase.
    always_comb begin
        state_d = state_q;
        if (!ENABLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SLOT_START;
                BLANK:   if (slot_cnt == BLANK_LAST) state_d = SHOW;
                SHOW:    if (slot_wrap) state_d = SLOT_START;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        seg_d = seg_q;
        if (!ENABLE) begin
            seg_d = '0;
        end else if (slot_wrap) begin
            seg_d = seg_q + 2'd1;
        end

        anode_d = ANODES_OFF;
        if (state_d == SHOW) begin
            anode_d[seg_d] = ~DIGIT_MASK[seg_d];
        end

        // Raised one cycle early so the registered pulse lines up with digit 3's last cycle.
        tick_d = ENABLE && (state_q != IDLE) && (slot_cnt == PRE_LAST) && (seg_q == 2'd3);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            seg_q   <= '0;
            anode_q <= ANODES_OFF;
            tick_q  <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
        end
    end

    assign SEG_SELECT  = seg_q;
    assign DIGIT_ANODE = anode_q;
    assign SCAN_TICK   = tick_q;

endmodule
